// File: rtl/mips_rename_unit.sv
// mips_rename_unit
// Register rename stage between decode and issue. Maps the 32 MIPS
// architectural registers onto NUM_PHYS physical tags. It uses a speculative
// map, a retirement map and a circular free list. One rename and one commit
// can happen per cycle. A flush restores the speculative state from the
// retirement state in a single cycle.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   ren_valid/ready   rename handshake
//   ren_rs/rt/rw      architectural sources / destination
//   ren_uses_rw       instruction writes a destination
//   ren_ps/pt         physical tags of the sources
//   ren_pw_new/old    allocated destination tag / previous mapping of rw
//   cmt_*             in-order commit: destination, allocated tag, tag to free
//   flush             discard all uncommitted renames
//   free_count        number of free-list entries
module mips_rename_unit #(
  parameter int NUM_PHYS = 64,
  parameter int NUM_ARCH = 32,
  parameter int PTAG_W   = $clog2(NUM_PHYS),
  parameter int FL_DEPTH = NUM_PHYS - NUM_ARCH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ren_valid,
  output logic              ren_ready,
  input  logic [4:0]        ren_rs,
  input  logic [4:0]        ren_rt,
  input  logic [4:0]        ren_rw,
  input  logic              ren_uses_rw,
  output logic [PTAG_W-1:0] ren_ps,
  output logic [PTAG_W-1:0] ren_pt,
  output logic [PTAG_W-1:0] ren_pw_new,
  output logic [PTAG_W-1:0] ren_pw_old,
  input  logic              cmt_valid,
  input  logic              cmt_uses_rw,
  input  logic [4:0]        cmt_rw,
  input  logic [PTAG_W-1:0] cmt_pw_new,
  input  logic [PTAG_W-1:0] cmt_pw_old,
  input  logic              flush,
  output logic [PTAG_W:0]   free_count
);

  localparam int PTR_W = (FL_DEPTH > 1) ? $clog2(FL_DEPTH) : 1;

  logic [PTAG_W-1:0] spec_map [NUM_ARCH];
  logic [PTAG_W-1:0] ret_map  [NUM_ARCH];
  logic [PTAG_W-1:0] fl       [FL_DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [PTR_W-1:0]  ret_head;
  logic [PTAG_W:0]   count;

  logic              dst;
  logic              alloc;
  logic              cmt_do;
  logic [PTR_W-1:0]  head_inc;
  logic [PTR_W-1:0]  tail_inc;
  logic [PTR_W-1:0]  ret_head_inc;

  // Depth need not be a power of two, so wrap explicitly.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FL_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    dst          = ren_uses_rw && (ren_rw != '0);
    ren_ready    = !rst && !flush && (count != '0);
    alloc        = ren_valid && ren_ready && dst;
    cmt_do       = cmt_valid && cmt_uses_rw && (cmt_rw != '0);
    head_inc     = ptr_inc(head);
    tail_inc     = ptr_inc(tail);
    ret_head_inc = ptr_inc(ret_head);

    // Sources read the mapping before this instruction's own write.
    ren_ps       = spec_map[ren_rs];
    ren_pt       = spec_map[ren_rt];
    ren_pw_old   = spec_map[ren_rw];
    ren_pw_new   = dst ? fl[head] : '0;
    free_count   = count;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_ARCH; i++) begin
        spec_map[i] <= PTAG_W'(i);
        ret_map[i]  <= PTAG_W'(i);
      end
      for (int unsigned k = 0; k < FL_DEPTH; k++) begin
        fl[k] <= PTAG_W'(NUM_ARCH + k);
      end
      head     <= '0;
      tail     <= '0;
      ret_head <= '0;
      count    <= (PTAG_W+1)'(FL_DEPTH);
    end else begin
      if (cmt_do) begin
        ret_map[cmt_rw] <= cmt_pw_new;
        fl[tail]        <= cmt_pw_old;
        tail            <= tail_inc;
        ret_head        <= ret_head_inc;
      end

      if (flush) begin
        // Recover from the post-commit retirement state, so a commit in the
        // flush cycle is folded into the restored map and allocate point.
        for (int unsigned i = 0; i < NUM_ARCH; i++) begin
          spec_map[i] <= (cmt_do && (cmt_rw == 5'(i))) ? cmt_pw_new : ret_map[i];
        end
        head  <= cmt_do ? ret_head_inc : ret_head;
        count <= (PTAG_W+1)'(FL_DEPTH);
      end else begin
        if (alloc) begin
          spec_map[ren_rw] <= fl[head];
          head             <= head_inc;
        end
        case ({alloc, cmt_do})
          2'b10:   count <= count - 1'b1;
          2'b01:   count <= count + 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

endmodule
